// File: rtl/imuldiv_muldiv_writeback.sv
// Writeback adapter for the iterative mul/div unit: in-order tag FIFO plus a one-entry
// registered writeback port. Define IMULDIV_WB_BYPASS_EN for a 0-cycle bypass when the port is idle.
module imuldiv_muldiv_writeback #(
  parameter int TAG_DEPTH = 2,
  parameter int PTR_W     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [4:0]  muldivreq_rd,
  output logic        tag_full,
  input  logic [63:0] muldivresp_msg_result,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy,
  output logic        wb_val,
  input  logic        wb_rdy,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(TAG_DEPTH);
  localparam logic [2:0]     FN_REM  = 3'd3;
  localparam logic [2:0]     FN_REMU = 3'd4;

  logic [2:0]       fn_q [TAG_DEPTH];
  logic [4:0]       rd_q [TAG_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic        wb_val_p1;
  logic [4:0]  wb_rd_p1;
  logic [31:0] wb_data_p1;

  logic        push, pop, push_ok, fifo_empty, err_set, bypass, load;
  logic [2:0]  head_fn;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  // Remainder lives in the upper word; every other code (including 5-7) takes the low word.
  function automatic logic [31:0] select_field(input logic [2:0] fn, input logic [63:0] result);
    if (fn == FN_REM || fn == FN_REMU) return result[63:32];
    return result[31:0];
  endfunction

  assign fifo_empty     = (count == '0);
  assign tag_full       = (count == DEPTH_C);
  assign muldivresp_rdy = !fifo_empty && (!wb_val_p1 || wb_rdy);

  assign push    = muldivreq_val && muldivreq_rdy;
  assign pop     = muldivresp_val && muldivresp_rdy;
  assign push_ok = push && (!tag_full || pop);
  assign err_set = (push && tag_full && !pop) || (muldivresp_val && fifo_empty);

  assign head_fn   = fn_q[head];
  assign head_rd   = rd_q[head];
  assign head_data = select_field(head_fn, muldivresp_msg_result);

`ifdef IMULDIV_WB_BYPASS_EN
  assign bypass = pop && !wb_val_p1;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed beat that is accepted immediately never needs the register.
  assign load = pop && !(bypass && wb_rdy);

  always_comb begin
    wb_val  = wb_val_p1;
    wb_rd   = wb_rd_p1;
    wb_data = wb_data_p1;
    if (bypass) begin
      wb_val  = 1'b1;
      wb_rd   = head_rd;
      wb_data = head_data;
    end
  end

  // Tag FIFO storage: written at tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fn_q[tail] <= muldivreq_msg_fn;
      rd_q[tail] <= muldivreq_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
      if (err_set) err <= 1'b1;
    end
  end

  // Writeback stage p1: response fire in cycle N is visible in cycle N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_val_p1  <= 1'b0;
      wb_rd_p1   <= '0;
      wb_data_p1 <= '0;
    end else if (load) begin
      wb_val_p1  <= 1'b1;
      wb_rd_p1   <= head_rd;
      wb_data_p1 <= head_data;
    end else if (wb_val_p1 && wb_rdy) begin
      wb_val_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imuldiv_muldiv_writeback.sv
// Directed self-checking bench for imuldiv_muldiv_writeback (default build, registered path).
module tb_imuldiv_muldiv_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        muldivreq_val, muldivreq_rdy;
  logic [2:0]  muldivreq_msg_fn;
  logic [4:0]  muldivreq_rd;
  logic        tag_full;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;
  logic        wb_val, wb_rdy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  imuldiv_muldiv_writeback #(.TAG_DEPTH(2), .PTR_W(1)) dut (
    .clk(clk), .reset(reset),
    .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_rd(muldivreq_rd),
    .tag_full(tag_full),
    .muldivresp_msg_result(muldivresp_msg_result),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tag(input logic [2:0] fn, input logic [4:0] rd);
    muldivreq_val = 1'b1; muldivreq_rdy = 1'b1;
    muldivreq_msg_fn = fn; muldivreq_rd = rd;
    tick();
    muldivreq_val = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] d);
    check({tag, "_val"}, 64'(wb_val), 64'(v));
    check({tag, "_rd"}, 64'(wb_rd), 64'(rd));
    check({tag, "_data"}, 64'(wb_data), 64'(d));
  endtask

  initial begin
    reset = 1'b1;
    muldivreq_val = 1'b0; muldivreq_rdy = 1'b0;
    muldivreq_msg_fn = '0; muldivreq_rd = '0;
    muldivresp_msg_result = '0; muldivresp_val = 1'b0;
    wb_rdy = 1'b1;
    tick(); tick();
    check_wb("reset", 1'b0, 5'd0, 32'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_full", 64'(tag_full), 64'd0);
    check("reset_resp_rdy", 64'(muldivresp_rdy), 64'd0);
    reset = 1'b0;
    tick();

    // MUL rd=7, low word selected
    push_tag(3'd0, 5'd7);
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'h0000_0001_0000_002A;
    #1 check("mul_resp_rdy", 64'(muldivresp_rdy), 64'd1);
    tick();
    muldivresp_val = 1'b0;
    check_wb("mul", 1'b1, 5'd7, 32'h2A);
    tick();
    check("mul_drain", 64'(wb_val), 64'd0);

    // REM rd=3 then DIVU rd=4, back-to-back responses
    push_tag(3'd3, 5'd3);
    push_tag(3'd2, 5'd4);
    check("two_tags_full", 64'(tag_full), 64'd1);
    muldivresp_val = 1'b1; muldivresp_msg_result = {32'd5, 32'd9};
    tick();
    check_wb("rem", 1'b1, 5'd3, 32'd5);
    muldivresp_msg_result = {32'd1, 32'd6};
    #1 check("b2b_resp_rdy", 64'(muldivresp_rdy), 64'd1);
    tick();
    muldivresp_val = 1'b0;
    check_wb("divu", 1'b1, 5'd4, 32'd6);
    tick();
    check("b2b_drain", 64'(wb_val), 64'd0);
    check("b2b_err", 64'(err), 64'd0);

    // Back-pressure: invalid fn 6 acts as MUL, DIV takes low word
    push_tag(3'd6, 5'd10);
    push_tag(3'd1, 5'd11);
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'hBEEF_0000_0000_0011;
    wb_rdy = 1'b0;
    tick();
    check_wb("fn6", 1'b1, 5'd10, 32'h11);
    muldivresp_msg_result = 64'hDEAD_0000_0000_0022;
    #1 check("stall_resp_rdy", 64'(muldivresp_rdy), 64'd0);
    tick();
    check_wb("stall_hold", 1'b1, 5'd10, 32'h11);
    wb_rdy = 1'b1;
    #1 check("unstall_resp_rdy", 64'(muldivresp_rdy), 64'd1);
    tick();
    muldivresp_val = 1'b0;
    check_wb("div_reload", 1'b1, 5'd11, 32'h22);
    tick();
    check("stall_drain", 64'(wb_val), 64'd0);

    // Overflow: third push while full is dropped and flags err
    push_tag(3'd0, 5'd1);
    push_tag(3'd0, 5'd2);
    check("ovf_pre_err", 64'(err), 64'd0);
    push_tag(3'd0, 5'd9);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_full", 64'(tag_full), 64'd1);
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'd100;
    tick();
    check_wb("ovf_pop1", 1'b1, 5'd1, 32'd100);
    muldivresp_msg_result = 64'd200;
    tick();
    muldivresp_val = 1'b0;
    check_wb("ovf_pop2", 1'b1, 5'd2, 32'd200);
    check("ovf_count_zero", 64'(tag_full), 64'd0);
    muldivresp_val = 1'b1;
    #1 check("ovf_empty_rdy", 64'(muldivresp_rdy), 64'd0);
    muldivresp_val = 1'b0;
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_err_clear", 64'(err), 64'd0);

    // Push and pop together while full: legal, count stays 2
    push_tag(3'd0, 5'd20);
    push_tag(3'd0, 5'd21);
    wb_rdy = 1'b0;
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'd77;
    muldivreq_val = 1'b1; muldivreq_rdy = 1'b1; muldivreq_msg_fn = 3'd0; muldivreq_rd = 5'd22;
    tick();
    muldivreq_val = 1'b0; muldivresp_val = 1'b0;
    check_wb("full_pushpop", 1'b1, 5'd20, 32'd77);
    check("full_pushpop_err", 64'(err), 64'd0);
    check("full_pushpop_full", 64'(tag_full), 64'd1);

    // Asynchronous reset mid-cycle drops outputs before any edge
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_wb_val", 64'(wb_val), 64'd0);
    check("async_full", 64'(tag_full), 64'd0);
    check("async_rd", 64'(wb_rd), 64'd0);
    tick();
    reset = 1'b0;
    wb_rdy = 1'b1;

    // Response with empty FIFO: never consumed, err sticky
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'd5;
    #1 check("empty_resp_rdy", 64'(muldivresp_rdy), 64'd0);
    tick();
    check("empty_err", 64'(err), 64'd1);
    check("empty_no_wb", 64'(wb_val), 64'd0);
    muldivresp_val = 1'b0;
    tick(); tick();
    check("err_sticky", 64'(err), 64'd1);
    reset = 1'b1;
    #1 check("err_reset", 64'(err), 64'd0);
    tick();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
